// File: rtl/cache_memory_system_pkg.sv
// Shared types and defaults for the direct-mapped write-back cache.
// Widths derive from the line index size.
package cache_memory_system_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    READY
  } state_t;

  localparam int INDEX_BITS_D     = 8;
  localparam int MEM_WORDS_LOG2_D = 12;
  localparam int MEM_LATENCY_D    = 8;
  localparam int TAG_BITS_D       = 32 - INDEX_BITS_D - 2;

  function automatic int tag_bits(input int ib);
    return 32 - ib - 2;
  endfunction

endpackage

// File: rtl/cache_memory_system_if.sv
// Processor-side request/response bundle of the data cache.
// master = MEM stage, slave = cache.
interface cache_memory_system_if;
  logic        re;
  logic        we;
  logic        we2;
  logic        we3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdatacache;
  logic        hit;
  logic        miss;
  logic        dirty;

  modport master (
    output re, we, we2, we3, address, writedata,
    input  readdatacache, hit, miss, dirty
  );

  modport slave (
    input  re, we, we2, we3, address, writedata,
    output readdatacache, hit, miss, dirty
  );
endinterface

// File: rtl/cache_memory_system_main_memory.sv
// Word-addressed backing store: one synchronous read/write port.
// The registered read output doubles as the cache fill buffer.
module main_memory #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wr,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= wdata;
    if (rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_memory_system.sv
// Direct-mapped write-back / write-allocate data cache with
// strobe-committed miss handling in front of main_memory.
module cache_memory_system
  import cache_memory_system_pkg::*;
#(
  parameter int INDEX_BITS     = INDEX_BITS_D,
  parameter int MEM_WORDS_LOG2 = MEM_WORDS_LOG2_D,
  parameter int MEM_LATENCY    = MEM_LATENCY_D
) (
  input logic                   clk,
  input logic                   rst_n,
  cache_memory_system_if.slave  bus
);

  localparam int TB    = tag_bits(INDEX_BITS);
  localparam int LINES = 2**INDEX_BITS;
  localparam int CW    = $clog2(MEM_LATENCY) + 1;

  state_t state, nstate;
  logic [CW-1:0] cnt;

  logic [TB-1:0] tag_q  [LINES];
  logic [31:0]   data_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wr;
  logic        v_dirty;

  logic [INDEX_BITS-1:0] idx, m_idx;
  logic [TB-1:0]         tag;
  logic                  req, lhit, vdirty_now, done;
  logic                  commit_wr, commit_rd;
  logic                  mem_wr, mem_rd;
  logic [MEM_WORDS_LOG2-1:0] mem_addr;
  logic [29:0]           v_word;
  logic [31:0]           fill;
  logic                  unused_bits;

  assign idx   = bus.address[INDEX_BITS+1:2];
  assign tag   = bus.address[31:INDEX_BITS+2];
  assign m_idx = m_addr[INDEX_BITS+1:2];
  assign req   = bus.re | bus.we;
  assign lhit  = valid_q[idx] & (tag_q[idx] == tag);
  assign vdirty_now = valid_q[idx] & dirty_q[idx];
  assign done  = cnt == CW'(MEM_LATENCY - 1);

  assign commit_wr = (state == READY) & m_wr & bus.we2;
  assign commit_rd = (state == READY) & ~m_wr & bus.we3;

  // Victim goes back to {victim tag, index}; fetch uses the miss address.
  assign v_word   = {tag_q[m_idx], m_idx};
  assign mem_wr   = (state == WRITEBACK) & done;
  assign mem_rd   = (state == FETCH) & done;
  assign mem_addr = (state == WRITEBACK)
                  ? v_word[MEM_WORDS_LOG2-1:0]
                  : m_addr[MEM_WORDS_LOG2+1:2];

  assign unused_bits = ^{bus.address[1:0], m_addr[1:0],
                         v_word[29:MEM_WORDS_LOG2]};

  main_memory #(.AW(MEM_WORDS_LOG2)) u_mem (
    .clk   (clk),
    .wr    (mem_wr),
    .rd    (mem_rd),
    .addr  (mem_addr),
    .wdata (data_q[m_idx]),
    .rdata (fill)
  );

  always_comb begin
    bus.hit   = 1'b0;
    bus.miss  = 1'b1;
    bus.dirty = v_dirty;
    if (state == IDLE) begin
      bus.hit   = req & lhit;
      bus.miss  = req & ~lhit;
      bus.dirty = vdirty_now;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (req && !lhit)
          nstate = vdirty_now ? WRITEBACK : FETCH;
      WRITEBACK: if (done) nstate = FETCH;
      FETCH:     if (done) nstate = READY;
      READY:
        if (commit_wr || commit_rd) nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wr    <= 1'b0;
      v_dirty <= 1'b0;
      bus.readdatacache <= '0;
    end else begin
      state <= nstate;
      if (state == nstate &&
          (state == WRITEBACK || state == FETCH))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == IDLE && req && !lhit) begin
        m_addr  <= bus.address;
        m_wdata <= bus.writedata;
        m_wr    <= bus.we;
        v_dirty <= vdirty_now;
      end
      if (mem_wr) v_dirty <= 1'b0;
      if (state == IDLE && bus.re && !bus.we && lhit)
        bus.readdatacache <= data_q[idx];
      if (commit_rd) bus.readdatacache <= fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '1;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (state == IDLE && bus.we && lhit) begin
        data_q[idx]  <= bus.writedata;
        dirty_q[idx] <= 1'b1;
      end
      if (mem_wr) dirty_q[m_idx] <= 1'b0;
      if (commit_wr || commit_rd) begin
        tag_q[m_idx]   <= m_addr[31:INDEX_BITS+2];
        data_q[m_idx]  <= commit_wr ? m_wdata : fill;
        dirty_q[m_idx] <= commit_wr;
        valid_q[m_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_memory_system.sv
// Scenario and randomized checks of cache_memory_system against
// a transaction-level cache/memory model.
module tb_cache_memory_system;

  localparam int IB = 8;
  localparam int MW = 12;
  localparam int L  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_memory_system_if bus();

  cache_memory_system #(
    .INDEX_BITS(IB), .MEM_WORDS_LOG2(MW), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem   [1<<MW];
  logic [31:0] c_data  [1<<IB];
  int          c_tag   [1<<IB];
  bit          c_dirty [1<<IB];

  logic        o_hit, o_miss, o_dirty;
  logic [31:0] o_rd;

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % (1 << IB));
  endfunction
  function automatic int tag_of(logic [31:0] a);
    return int'(a >> (IB + 2));
  endfunction
  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % (1 << MW));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < (1<<IB); i++) begin
      c_tag[i] = 0; c_data[i] = '0; c_dirty[i] = 0;
    end
  endfunction

  task automatic model_do(input bit wr, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd);
    int i;
    i = idx_of(a);
    rd = 'x;
    if (c_tag[i] != tag_of(a)) begin
      if (c_dirty[i])
        m_mem[(c_tag[i] * (1<<IB) + i) % (1<<MW)] = c_data[i];
      c_tag[i]   = tag_of(a);
      c_data[i]  = m_mem[word_of(a)];
      c_dirty[i] = 0;
    end
    if (wr) begin
      c_data[i] = wd; c_dirty[i] = 1;
    end else begin
      rd = c_data[i];
    end
  endtask

  task automatic req(input bit wr, input logic [31:0] a,
                     input logic [31:0] wd);
    @(negedge clk);
    bus.re = !wr; bus.we = wr;
    bus.address = a; bus.writedata = wd;
    #1;
    o_hit = bus.hit; o_miss = bus.miss; o_dirty = bus.dirty;
    @(posedge clk); #1;
    o_rd = bus.readdatacache;
    bus.re = 1'b0; bus.we = 1'b0;
  endtask

  task automatic strobe(input bit wr);
    @(negedge clk);
    bus.we2 = wr; bus.we3 = !wr;
    @(posedge clk); #1;
    o_rd = bus.readdatacache;
    bus.we2 = 1'b0; bus.we3 = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    @(negedge clk);
    bus.address = a;
    #1;
    o_hit = bus.hit; o_miss = bus.miss; o_dirty = bus.dirty;
  endtask

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] wd);
    req(wr, a, wd);
    if (o_miss) begin
      repeat (2*L + 2) @(posedge clk);
      strobe(wr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.readdatacache !== 32'h0) begin
      fails++;
      $display("FAIL reset_rd got %h want 0", bus.readdatacache);
    end
    look(32'h50);
    tests++;
    if ({o_hit, o_miss, o_dirty} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle hmd got %b want 000",
               {o_hit, o_miss, o_dirty});
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] r;
    req(1'b1, 32'h50, 32'h7);
    model_do(1'b1, 32'h50, 32'h7, r);
    tests++;
    if ({o_hit, o_miss} !== 2'b10) begin
      fails++;
      $display("FAIL wr_hit hm got %b want 10", {o_hit, o_miss});
    end
    look(32'h50);
    tests++;
    if (o_dirty !== 1'b1) begin
      fails++;
      $display("FAIL wr_hit_dirty got %b want 1", o_dirty);
    end
  endtask

  task automatic test_read_hit();
    req(1'b0, 32'h50, 32'h0);
    tests++;
    if (o_hit !== 1'b1 || o_rd !== 32'h7) begin
      fails++;
      $display("FAIL rd_hit got hit=%b rd=%h want 1 00000007",
               o_hit, o_rd);
    end
  endtask

  task automatic test_clean_write_miss();
    logic [31:0] r;
    req(1'b1, 32'h1006, 32'h12345678);
    tests++;
    if ({o_hit, o_miss, o_dirty} !== 3'b010) begin
      fails++;
      $display("FAIL cwm_detect hmd got %b want 010",
               {o_hit, o_miss, o_dirty});
    end
    repeat (20) @(posedge clk);
    look(32'h1006);
    tests++;
    if ({o_hit, o_miss} !== 2'b01) begin
      fails++;
      $display("FAIL cwm_pending hm got %b want 01", {o_hit, o_miss});
    end
    strobe(1'b1);
    model_do(1'b1, 32'h1006, 32'h12345678, r);
    look(32'h1006);
    tests++;
    if ({o_miss, o_dirty} !== 2'b01) begin
      fails++;
      $display("FAIL cwm_commit md got %b want 01", {o_miss, o_dirty});
    end
    req(1'b0, 32'h1006, 32'h0);
    tests++;
    if (o_hit !== 1'b1 || o_rd !== 32'h12345678) begin
      fails++;
      $display("FAIL cwm_reread got hit=%b rd=%h want 1 12345678",
               o_hit, o_rd);
    end
  endtask

  task automatic test_dirty_read_miss();
    logic [31:0] r;
    req(1'b0, 32'h2006, 32'h0);
    tests++;
    if ({o_miss, o_dirty} !== 2'b11) begin
      fails++;
      $display("FAIL drm_detect md got %b want 11", {o_miss, o_dirty});
    end
    repeat (2*L + 2) @(posedge clk);
    strobe(1'b0);
    model_do(1'b0, 32'h2006, 32'h0, r);
    tests++;
    if (o_rd !== r) begin
      fails++;
      $display("FAIL drm_fill got %h want %h", o_rd, r);
    end
    look(32'h2006);
    tests++;
    if (o_dirty !== 1'b0) begin
      fails++;
      $display("FAIL drm_clean got %b want 0", o_dirty);
    end
  endtask

  task automatic test_write_after();
    logic [31:0] r;
    req(1'b1, 32'h2005, 32'h87654321);
    model_do(1'b1, 32'h2005, 32'h87654321, r);
    tests++;
    if ({o_hit, o_miss} !== 2'b10) begin
      fails++;
      $display("FAIL wa_hit hm got %b want 10", {o_hit, o_miss});
    end
    look(32'h2004);
    tests++;
    if (o_dirty !== 1'b1) begin
      fails++;
      $display("FAIL wa_dirty got %b want 1", o_dirty);
    end
    req(1'b0, 32'h2004, 32'h0);
    tests++;
    if (o_rd !== 32'h87654321) begin
      fails++;
      $display("FAIL wa_reread got %h want 87654321", o_rd);
    end
    access(1'b0, 32'h1006, 32'h0);
    model_do(1'b0, 32'h1006, 32'h0, r);
    tests++;
    if (o_rd !== r || r !== 32'h12345678) begin
      fails++;
      $display("FAIL wa_wb_mem got %h want 12345678", o_rd);
    end
  endtask

  task automatic test_strobe_mismatch();
    logic [31:0] r;
    req(1'b1, 32'h3008, 32'habc);
    repeat (2*L + 2) @(posedge clk);
    strobe(1'b0);
    look(32'h3008);
    tests++;
    if (o_miss !== 1'b1) begin
      fails++;
      $display("FAIL sm_ignored miss got %b want 1", o_miss);
    end
    strobe(1'b1);
    model_do(1'b1, 32'h3008, 32'habc, r);
    look(32'h3008);
    tests++;
    if ({o_miss, o_dirty} !== 2'b01) begin
      fails++;
      $display("FAIL sm_commit md got %b want 01", {o_miss, o_dirty});
    end
    req(1'b0, 32'h3008, 32'h0);
    tests++;
    if (o_rd !== 32'habc) begin
      fails++;
      $display("FAIL sm_reread got %h want 00000abc", o_rd);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] r;
    req(1'b0, 32'h1008, 32'h0);
    tests++;
    if ({o_miss, o_dirty} !== 2'b11) begin
      fails++;
      $display("FAIL rmm_detect md got %b want 11", {o_miss, o_dirty});
    end
    repeat (3) @(posedge clk);
    do_reset();
    look(32'h50);
    tests++;
    if (o_dirty !== 1'b0) begin
      fails++;
      $display("FAIL rmm_clean got %b want 0", o_dirty);
    end
    req(1'b0, 32'h8, 32'h0);
    tests++;
    if (o_hit !== 1'b1 || o_rd !== 32'h0) begin
      fails++;
      $display("FAIL rmm_line got hit=%b rd=%h want 1 0", o_hit, o_rd);
    end
    access(1'b0, 32'h3008, 32'h0);
    model_do(1'b0, 32'h3008, 32'h0, r);
    tests++;
    if (o_rd !== r) begin
      fails++;
      $display("FAIL rmm_mem got %h want %h", o_rd, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, r;
    bit wr, ehit, edirty;
    int i;
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom % 2);
      a  = ($urandom % 16) << (IB + 2);
      a  = a | ((4 + $urandom % 3) << 2) | ($urandom % 4);
      wd = $urandom;
      i  = idx_of(a);
      ehit   = c_tag[i] == tag_of(a);
      edirty = c_dirty[i];
      access(wr, a, wd);
      tests++;
      if ({o_hit, o_miss, o_dirty} !== {ehit, !ehit, edirty}) begin
        fails++;
        $display("FAIL rnd_status n=%0d a=%h got %b want %b", n, a,
                 {o_hit, o_miss, o_dirty}, {ehit, !ehit, edirty});
      end
      model_do(wr, a, wd, r);
      if (!wr) begin
        tests++;
        if (o_rd !== r) begin
          fails++;
          $display("FAIL rnd_rd n=%0d a=%h got %h want %h",
                   n, a, o_rd, r);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < (1<<MW); k++) m_mem[k] = '0;
    model_reset();
    bus.re = 1'b0; bus.we = 1'b0;
    bus.we2 = 1'b0; bus.we3 = 1'b0;
    bus.address = '0; bus.writedata = '0;
    test_reset();
    test_write_hit();
    test_read_hit();
    test_clean_write_miss();
    test_dirty_read_miss();
    test_write_after();
    test_strobe_mismatch();
    test_reset_mid_miss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_memory_system.md
Name: cache_memory_system

Overview:
Single-level memory subsystem: direct-mapped, write-back, write-allocate data cache in front of a word-addressed main memory model. A processor-side port issues word reads/writes. The block reports hit, miss and victim-dirty status. Misses run an internal writeback/fetch sequence, then wait for an explicit commit strobe: we2 for a write miss, we3 for a read miss. Sits between the pipeline's MEM stage and backing store.

Parameters:
INDEX_BITS, 8, cache lines = 2^INDEX_BITS (one 32-bit word per line); index = address[INDEX_BITS+1:2]
MEM_WORDS_LOG2, 12, main memory depth in words; memory index = address[MEM_WORDS_LOG2+1:2]
MEM_LATENCY, 8, cycles per main-memory transfer (writeback or fetch), must be >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
re  input  1  read request
we  input  1  write request (wins over re if both high)
we2  input  1  commit strobe for a pending write miss
we3  input  1  commit strobe for a pending read miss
address  input  32  byte address; bits [1:0] ignored; tag = address[31:INDEX_BITS+2]
writedata  input  32  store data
readdatacache  output  32  registered read data
hit  output  1  request hits a valid line
miss  output  1  miss pending or detected
dirty  output  1  addressed (or latched victim) line is valid and dirty

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All lines valid=1, tag=0, data=0, dirty=0.
  - FSM goes to IDLE; readdatacache=0.
  - Reset mid-miss aborts the sequence with no memory or cache update.
  - Main memory is not reset; it is zero-initialised at time 0. This keeps the reset cache coherent for addresses below 2^(INDEX_BITS+2).
- States: IDLE, WRITEBACK, FETCH, READY.
- IDLE outputs (combinational):
  - hit = (re|we) & valid & tag match.
  - miss = (re|we) & ~hit.
  - dirty = valid & dirty bit of the line at address's index.
- IDLE write hit: at the edge, the line word is replaced by writedata and dirty is set; no memory access.
- IDLE read hit: at the edge, readdatacache is loaded with the line word (1-cycle latency).
- IDLE miss: at the edge, latch address, writedata, request type (write if we) and victim dirty.
  - Victim dirty: go to WRITEBACK.
  - Otherwise: go to FETCH.
- WRITEBACK: after MEM_LATENCY cycles, write the victim word to memory at {victim tag, index}, clear the victim dirty flag, go to FETCH.
- FETCH: after MEM_LATENCY cycles, capture the memory word at the latched address into a fill buffer, go to READY.
- READY: holds until the matching strobe arrives.
  - Pending write and we2=1: install line with tag from the latched address, data = latched writedata, dirty=1.
  - Pending read and we3=1: install fill data with dirty=0, load readdatacache with fill data.
  - Either case then returns to IDLE.
  - A non-matching strobe is ignored.
- Outside IDLE:
  - miss=1, hit=0.
  - dirty reflects the latched victim flag.
  - re/we ignored; new requests are not queued.
- we2/we3 in IDLE: no effect.
- No request in IDLE: hit=0, miss=0, readdatacache holds.

Decomposition:
- Shared package: state enum (IDLE/WRITEBACK/FETCH/READY); default parameter constants; tag/index width localparams derived from INDEX_BITS.
- One natural sub-module: main_memory (synchronous word RAM, single read/write port), instantiated by cache_memory_system.
- Cache arrays and FSM stay in the top.

Test Plan:
- Reset, then we=1 addr=0x50 data=0x7 for 1 cycle -> hit=1, miss=0; next cycle addr 0x50 dirty=1.
- re=1 addr=0x50 -> hit=1; after the edge readdatacache=0x00000007.
- we=1 addr=0x1006 data=0x12345678 (clean miss) -> miss=1 until commit.
  - Wait 20 cycles, pulse we2 -> line installed, dirty=1.
  - Then re addr=0x1006 -> hit=1, readdatacache=0x12345678.
- re=1 addr=0x2006 (same index, dirty victim) -> miss=1, dirty=1.
  - Writeback+fetch take 2*MEM_LATENCY cycles; pulse we3 -> readdatacache=0x0.
  - Memory word 0x1004 now holds 0x12345678; the line is clean.
- we=1 addr=0x2005 data=0x87654321 after the above -> write hit, dirty=1, no miss.
  - Re-read gives 0x87654321.
- Strobe/reset edges:
  - we3 asserted during a pending write miss -> ignored, stays READY.
  - rst_n low during WRITEBACK -> returns to IDLE, all lines clean, memory unchanged.
